bitmask_combination_enumerator: RTL and testbench
=================================================

Name: bitmask_combination_enumerator

Overview:
- Sequential enumerator: emits every WORD_WIDTH-bit mask with exactly K set bits, ascending numeric order, one per accepted handshake.
- Consumes the combinational next-mask-with-same-popcount stage: instantiates it on the registered current mask to form the successor.
- Sits between a control source (start request carrying K) and any downstream consumer of candidate subsets, e.g. a combination search or arbiter sweep.

Parameters:
- WORD_WIDTH, 8, mask width; must be >= 2.
- POPCOUNT_WIDTH, 4, width of start_popcount; must hold WORD_WIDTH.
- INDEX_WIDTH, 16, width of mask_index (feature only).

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- start_valid  input  1  start request valid.
- start_ready  output  1  high only in IDLE.
- start_popcount  input  POPCOUNT_WIDTH  K, the set-bit count to enumerate.
- start_error  output  1  one-cycle pulse: accepted start had K > WORD_WIDTH.
- abort  input  1  cancels a running sequence.
- mask_valid  output  1  mask is presented.
- mask_ready  input  1  consumer accepts mask.
- mask  output  WORD_WIDTH  current mask.
- mask_last  output  1  mask is the final one of its sequence.
- busy  output  1  high in RUN.

Behaviour:
- Reset values: state IDLE; mask 0; mask_valid, mask_last, start_error, busy 0; start_ready 1 (combinational from state).
- Asynchronous clear mid-sequence abandons it immediately. Next start restarts from the first mask.
- States: IDLE, RUN.
- IDLE:
  - Start accepted on start_valid & start_ready.
  - K <= WORD_WIDTH: load mask = (1<<K)-1 and go to RUN. mask_valid rises the cycle after acceptance (latency 1).
  - K > WORD_WIDTH: stay IDLE; start_error high for exactly the next cycle; no masks are emitted.
- RUN:
  - mask_valid = 1. mask and mask_last are held stable while mask_valid & !mask_ready.
  - On handshake with mask_last = 0: mask <= successor from the next-popcount stage. Throughput is one mask per cycle with mask_ready held high.
  - On handshake with mask_last = 1: go to IDLE and drop mask_valid the next cycle. A new start can be accepted that following cycle, not in the same cycle.
  - abort in RUN: go to IDLE next cycle with mask_valid 0. abort has precedence over a simultaneous handshake; that mask counts as not consumed by the block.
  - abort in IDLE: no effect.
- mask_last is registered and equals (mask == ((1<<K)-1) << (WORD_WIDTH-K)).
- Registered K is held for the whole sequence; start_popcount is ignored while in RUN.
- K = 0: a single mask 0 with mask_last = 1. The successor stage is never consulted.
- K = WORD_WIDTH: a single all-ones mask with mask_last = 1.
- Sequence length is C(WORD_WIDTH, K). The successor is never used after the last mask, so its wrap-around output is never loaded.
- busy = (state == RUN).

Optional Feature:
- Macro: BITMASK_COMBINATION_ENUMERATOR_INDEX_EN.
- Defined:
  - Adds output port mask_index [INDEX_WIDTH-1:0], reset 0, set to 0 on start acceptance.
  - mask_index increments on each mask handshake, so it is the 0-based position of the mask currently presented.
  - Wraps modulo 2^INDEX_WIDTH.
  - Held during stalls; not changed by abort.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- WORD_WIDTH=4, K=2, mask_ready held 1 -> masks 0011,0101,0110,1001,1010,1100 on consecutive cycles. mask_last only on 1100. start_ready returns 1 the cycle after. With INDEX_EN, mask_index reads 0..5.
- WORD_WIDTH=8, K=3, mask_ready toggling randomly -> exactly 56 masks in ascending order, each with popcount 3, no duplicates. mask is stable during every stall. Final mask 11100000 carries mask_last.
- K=0 -> single mask 00000000 with mask_last=1. K=8 -> single mask 11111111 with mask_last=1. K=9 -> no mask_valid, one-cycle start_error, state stays IDLE.
- WORD_WIDTH=4, K=2: abort asserted together with a handshake on mask 0101 -> mask_valid 0 the next cycle. A new start with K=1 then emits 0001,0010,0100,1000.
- clear asserted asynchronously mid-sequence (between clock edges) -> mask_valid, busy and mask go to 0 immediately, start_ready goes to 1. The next start begins from 0011.
- start_valid held high with K=2 throughout a sequence -> start_popcount ignored in RUN. The second sequence is accepted only in the IDLE cycle after the last handshake.

Source files
------------

// File: rtl/bitmask_combination_enumerator_if.sv
// Handshake bundle for bitmask_combination_enumerator.
// The start channel carries K; the mask channel streams candidate subsets.
// Optional macro BITMASK_COMBINATION_ENUMERATOR_INDEX_EN adds mask_index.
//
// Handshake rule: a transfer happens on a rising clock edge where the
// producer's valid and the consumer's ready are both high. While valid is
// high and ready is low, the producer holds its payload stable.
// On the mask channel, abort wins over a simultaneous transfer.
interface bitmask_combination_enumerator_if #(
    parameter int WORD_WIDTH     = 8,
    parameter int POPCOUNT_WIDTH = 4,
    parameter int INDEX_WIDTH    = 16
);
    logic                      start_valid;
    logic                      start_ready;
    logic [POPCOUNT_WIDTH-1:0] start_popcount;
    logic                      start_error;
    logic                      abort;
    logic                      mask_valid;
    logic                      mask_ready;
    logic [WORD_WIDTH-1:0]     mask;
    logic                      mask_last;
    logic                      busy;
`ifdef BITMASK_COMBINATION_ENUMERATOR_INDEX_EN
    logic [INDEX_WIDTH-1:0]    mask_index;

    // Enumerator side.
    modport master (
        input  start_valid, start_popcount, abort, mask_ready,
        output start_ready, start_error, mask_valid, mask, mask_last, busy,
               mask_index
    );

    // Control source / consumer side.
    modport slave (
        output start_valid, start_popcount, abort, mask_ready,
        input  start_ready, start_error, mask_valid, mask, mask_last, busy,
               mask_index
    );
`else
    // Enumerator side.
    modport master (
        input  start_valid, start_popcount, abort, mask_ready,
        output start_ready, start_error, mask_valid, mask, mask_last, busy
    );

    // Control source / consumer side.
    modport slave (
        output start_valid, start_popcount, abort, mask_ready,
        input  start_ready, start_error, mask_valid, mask, mask_last, busy
    );
`endif
endinterface

// File: rtl/bitmask_combination_enumerator.sv
// bitmask_combination_enumerator: streams every WORD_WIDTH-bit mask with
// exactly K set bits in ascending order, one mask per accepted handshake.
// bitmask_next_popcount is the combinational successor stage used on the
// registered current mask.
// Optional macro BITMASK_COMBINATION_ENUMERATOR_INDEX_EN adds mask_index,
// the 0-based position of the presented mask within its sequence.

// Next larger value with the same popcount (Gosper's step, with the
// divide replaced by a shift by the trailing-zero count). Input 0 and the
// last mask of a sequence produce meaningless wrap-around results; the
// enumerator never loads those.
module bitmask_next_popcount #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] mask_in,
    output logic [WORD_WIDTH-1:0] mask_out
);
    logic [WORD_WIDTH-1:0] lowest;
    logic [WORD_WIDTH-1:0] ripple;
    logic [WORD_WIDTH-1:0] ones;
    int                    tz;
    logic                  found;

    // Trailing-zero count, then carry the lowest run up and refill below it.
    always_comb begin
        tz    = 0;
        found = 1'b0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (!found && mask_in[i]) begin
                tz    = i;
                found = 1'b1;
            end
        end
        lowest   = mask_in & (~mask_in + WORD_WIDTH'(1));
        ripple   = mask_in + lowest;
        ones     = ((ripple ^ mask_in) >> 2) >> tz;
        mask_out = ripple | ones;
    end
endmodule

module bitmask_combination_enumerator #(
    parameter int WORD_WIDTH     = 8,
    parameter int POPCOUNT_WIDTH = 4,
    parameter int INDEX_WIDTH    = 16
) (
    input logic clock,
    input logic clear,
    bitmask_combination_enumerator_if.master bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WORD_WIDTH-1:0]     ALL_ONES = '1;
    localparam logic [POPCOUNT_WIDTH-1:0] K_MAX    = POPCOUNT_WIDTH'(WORD_WIDTH);

    state_t                    state, state_next;
    logic [WORD_WIDTH-1:0]     mask_r, mask_next;
    logic                      last_r, last_next;
    logic [POPCOUNT_WIDTH-1:0] k_r, k_next;
    logic                      err_r, err_next;
    logic                      start_accept;
    logic                      mask_take;
    logic [WORD_WIDTH-1:0]     succ;

    // Lowest mask with k set bits; k == WORD_WIDTH shifts everything out.
    function automatic logic [WORD_WIDTH-1:0] first_mask(input logic [POPCOUNT_WIDTH-1:0] k);
        return ~(ALL_ONES << k);
    endfunction

    // Highest mask with k set bits: the low run moved to the top.
    function automatic logic [WORD_WIDTH-1:0] final_mask(input logic [POPCOUNT_WIDTH-1:0] k);
        return first_mask(k) << (K_MAX - k);
    endfunction

    bitmask_next_popcount #(.WORD_WIDTH(WORD_WIDTH)) u_next (
        .mask_in  (mask_r),
        .mask_out (succ)
    );

    // State and datapath registers; clear abandons any running sequence.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            mask_r <= '0;
            last_r <= 1'b0;
            k_r    <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_next;
            mask_r <= mask_next;
            last_r <= last_next;
            k_r    <= k_next;
            err_r  <= err_next;
        end
    end

    // Next-state logic: start loading in IDLE, stepping/abort in RUN.
    always_comb begin
        state_next   = state;
        mask_next    = mask_r;
        last_next    = last_r;
        k_next       = k_r;
        err_next     = 1'b0;
        start_accept = 1'b0;
        mask_take    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    start_accept = 1'b1;
                    if (bus.start_popcount > K_MAX) begin
                        err_next = 1'b1;
                    end else begin
                        k_next     = bus.start_popcount;
                        mask_next  = first_mask(bus.start_popcount);
                        last_next  = (first_mask(bus.start_popcount) ==
                                      final_mask(bus.start_popcount));
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // The presented mask is dropped, even if ready was high.
                    state_next = IDLE;
                    last_next  = 1'b0;
                end else if (bus.mask_ready) begin
                    mask_take = 1'b1;
                    if (last_r) begin
                        state_next = IDLE;
                        last_next  = 1'b0;
                    end else begin
                        mask_next = succ;
                        last_next = (succ == final_mask(k_r));
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.mask_valid  = (state == RUN);
    assign bus.busy        = (state == RUN);
    assign bus.mask        = mask_r;
    assign bus.mask_last   = last_r;
    assign bus.start_error = err_r;

`ifdef BITMASK_COMBINATION_ENUMERATOR_INDEX_EN
    logic [INDEX_WIDTH-1:0] index_r;

    // Position counter: zeroed on any accepted start, bumped per handshake.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            index_r <= '0;
        end else if (start_accept) begin
            index_r <= '0;
        end else if (mask_take) begin
            index_r <= index_r + INDEX_WIDTH'(1);
        end
    end

    assign bus.mask_index = index_r;
`endif
endmodule

// File: tb/tb_bitmask_combination_enumerator.sv
// Bench for bitmask_combination_enumerator: a 4-bit and an 8-bit instance
// share the clock and clear. A sequence model watches the handshakes on
// every falling edge; directed tests pin the model with literal masks.
module tb_bitmask_combination_enumerator;
    logic clock;
    logic clear;

    bitmask_combination_enumerator_if #(.WORD_WIDTH(4), .POPCOUNT_WIDTH(4), .INDEX_WIDTH(16)) bus4 ();
    bitmask_combination_enumerator_if #(.WORD_WIDTH(8), .POPCOUNT_WIDTH(4), .INDEX_WIDTH(16)) bus8 ();

    bitmask_combination_enumerator #(.WORD_WIDTH(4), .POPCOUNT_WIDTH(4), .INDEX_WIDTH(16)) u_dut4 (
        .clock (clock),
        .clear (clear),
        .bus   (bus4)
    );

    bitmask_combination_enumerator #(.WORD_WIDTH(8), .POPCOUNT_WIDTH(4), .INDEX_WIDTH(16)) u_dut8 (
        .clock (clock),
        .clear (clear),
        .bus   (bus8)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int pass_count  = 0;
    int total_count = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [7:0]  got_q0[$];
    logic [7:0]  got_q1[$];
    logic        active     [2];
    logic        err_pend   [2];
    logic        stall_pend [2];
    logic [7:0]  stall_mask [2];
    logic [15:0] seq_pos    [2];

    logic [7:0] exp_w4_k2 [6];
    logic [7:0] exp_w4_k1 [4];

    task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
        total_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("FAIL %s dut=%0d got=%h want=%h t=%0t", name, id, got, want, $time);
        end
    endtask

    function automatic int exp_size(input int id);
        return (id == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int got_size(input int id);
        return (id == 0) ? got_q0.size() : got_q1.size();
    endfunction

    function automatic logic [7:0] got_at(input int id, input int i);
        return (id == 0) ? got_q0[i] : got_q1[i];
    endfunction

    // Model: all w-bit values with popcount k, in ascending numeric order.
    task automatic fill_expected(input int id, input int w, input int k);
        for (int v = 0; v < (1 << w); v++) begin
            if ($countones(v) == k) begin
                if (id == 0) exp_q0.push_back(8'(v));
                else         exp_q1.push_back(8'(v));
            end
        end
    endtask

    task automatic flush_expected(input int id);
        if (id == 0) exp_q0.delete();
        else         exp_q1.delete();
    endtask

    // One model step: check what the DUT presents now, then advance the
    // model by the inputs that the next rising edge will see.
    task automatic model_step(input int id, input logic sv, input logic [3:0] k,
                              input logic sr, input logic serr, input logic ab,
                              input logic mv, input logic mr, input logic [7:0] m,
                              input logic ml, input logic bz, input logic [15:0] idx);
        int         w;
        int         qs;
        logic [7:0] front;
        w = (id == 0) ? 4 : 8;
        if (clear) begin
            chk("reset_mask_valid", id, 16'(mv), 16'd0);
            chk("reset_mask", id, 16'(m), 16'd0);
            chk("reset_start_ready", id, 16'(sr), 16'd1);
            chk("reset_busy", id, 16'(bz), 16'd0);
            chk("reset_mask_last", id, 16'(ml), 16'd0);
            chk("reset_start_error", id, 16'(serr), 16'd0);
            flush_expected(id);
            active[id]     = 1'b0;
            err_pend[id]   = 1'b0;
            stall_pend[id] = 1'b0;
            seq_pos[id]    = '0;
            return;
        end
        chk("start_ready", id, 16'(sr), 16'(!active[id]));
        chk("busy", id, 16'(bz), 16'(active[id]));
        chk("mask_valid", id, 16'(mv), 16'(active[id]));
        chk("start_error", id, 16'(serr), 16'(err_pend[id]));
        err_pend[id] = 1'b0;
        if (active[id]) begin
            qs    = exp_size(id);
            front = (id == 0) ? exp_q0[0] : exp_q1[0];
            chk("mask", id, 16'(m), 16'(front));
            chk("mask_last", id, 16'(ml), 16'(qs == 1));
            if (stall_pend[id]) chk("stall_mask", id, 16'(m), 16'(stall_mask[id]));
`ifdef BITMASK_COMBINATION_ENUMERATOR_INDEX_EN
            chk("mask_index", id, idx, seq_pos[id]);
`else
            if (idx != 16'd0) $display("note: unexpected index value %h", idx);
`endif
        end
        if (mv && mr && !ab) begin
            if (id == 0) got_q0.push_back(m);
            else         got_q1.push_back(m);
        end
        stall_pend[id] = 1'b0;
        if (!active[id]) begin
            if (sv) begin
                if (int'(k) > w) begin
                    err_pend[id] = 1'b1;
                end else begin
                    flush_expected(id);
                    fill_expected(id, w, int'(k));
                    active[id]  = 1'b1;
                    seq_pos[id] = '0;
                end
            end
        end else if (ab) begin
            flush_expected(id);
            active[id] = 1'b0;
        end else if (mr) begin
            if (id == 0) void'(exp_q0.pop_front());
            else         void'(exp_q1.pop_front());
            seq_pos[id] = seq_pos[id] + 16'd1;
            if (exp_size(id) == 0) active[id] = 1'b0;
        end else begin
            stall_pend[id] = 1'b1;
            stall_mask[id] = m;
        end
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clock) begin
        logic [15:0] idx4;
        logic [15:0] idx8;
`ifdef BITMASK_COMBINATION_ENUMERATOR_INDEX_EN
        idx4 = bus4.mask_index;
        idx8 = bus8.mask_index;
`else
        idx4 = 16'd0;
        idx8 = 16'd0;
`endif
        model_step(0, bus4.start_valid, bus4.start_popcount, bus4.start_ready, bus4.start_error,
                   bus4.abort, bus4.mask_valid, bus4.mask_ready, 8'(bus4.mask), bus4.mask_last,
                   bus4.busy, idx4);
        model_step(1, bus8.start_valid, bus8.start_popcount, bus8.start_ready, bus8.start_error,
                   bus8.abort, bus8.mask_valid, bus8.mask_ready, bus8.mask, bus8.mask_last,
                   bus8.busy, idx8);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic busy_of(input int id);
        return (id == 0) ? bus4.busy : bus8.busy;
    endfunction

    task automatic start_seq(input int id, input logic [3:0] k);
        if (id == 0) begin
            bus4.start_valid = 1'b1; bus4.start_popcount = k;
        end else begin
            bus8.start_valid = 1'b1; bus8.start_popcount = k;
        end
        tick();
        if (id == 0) bus4.start_valid = 1'b0;
        else         bus8.start_valid = 1'b0;
    endtask

    task automatic wait_idle(input int id, input int budget, input logic rand_ready, output int cycles);
        cycles = 0;
        while (busy_of(id) && cycles < budget) begin
            if (rand_ready) begin
                if (id == 0) bus4.mask_ready = 1'($urandom_range(0, 1));
                else         bus8.mask_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cycles++;
        end
        chk("idle_timeout", id, 16'(busy_of(id)), 16'd0);
    endtask

    task automatic clear_got(input int id);
        if (id == 0) got_q0.delete();
        else         got_q1.delete();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cycles;
        exp_w4_k2 = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C};
        exp_w4_k1 = '{8'h01, 8'h02, 8'h04, 8'h08};
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; err_pend[i] = 1'b0; stall_pend[i] = 1'b0;
            stall_mask[i] = '0; seq_pos[i] = '0;
        end
        clear = 1'b1;
        bus4.start_valid = 1'b0; bus4.start_popcount = '0; bus4.abort = 1'b0; bus4.mask_ready = 1'b1;
        bus8.start_valid = 1'b0; bus8.start_popcount = '0; bus8.abort = 1'b0; bus8.mask_ready = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        tick();

        // W=4, K=2, ready held high: six masks on consecutive cycles.
        clear_got(0);
        start_seq(0, 4'd2);
        wait_idle(0, 50, 1'b0, cycles);
        chk("w4k2_cycles", 0, 16'(cycles), 16'd6);
        chk("w4k2_count", 0, 16'(got_size(0)), 16'd6);
        for (int i = 0; i < 6; i++) chk("w4k2_mask", 0, 16'(got_at(0, i)), 16'(exp_w4_k2[i]));
        tick();

        // W=8, K=3 with random backpressure: 56 masks ending at 11100000.
        clear_got(1);
        start_seq(1, 4'd3);
        wait_idle(1, 2000, 1'b1, cycles);
        bus8.mask_ready = 1'b1;
        chk("w8k3_count", 1, 16'(got_size(1)), 16'd56);
        chk("w8k3_first", 1, 16'(got_at(1, 0)), 16'h0007);
        chk("w8k3_final", 1, 16'(got_at(1, 55)), 16'h00E0);
        tick();

        // K=0, K=8 single masks; K=9 rejected with a one-cycle error.
        clear_got(1);
        start_seq(1, 4'd0);
        wait_idle(1, 20, 1'b0, cycles);
        chk("k0_count", 1, 16'(got_size(1)), 16'd1);
        chk("k0_mask", 1, 16'(got_at(1, 0)), 16'h0000);
        clear_got(1);
        start_seq(1, 4'd8);
        wait_idle(1, 20, 1'b0, cycles);
        chk("k8_count", 1, 16'(got_size(1)), 16'd1);
        chk("k8_mask", 1, 16'(got_at(1, 0)), 16'h00FF);
        clear_got(1);
        start_seq(1, 4'd9);
        chk("k9_error", 1, 16'(bus8.start_error), 16'd1);
        chk("k9_valid", 1, 16'(bus8.mask_valid), 16'd0);
        chk("k9_ready", 1, 16'(bus8.start_ready), 16'd1);
        tick();
        chk("k9_error_drop", 1, 16'(bus8.start_error), 16'd0);
        chk("k9_count", 1, 16'(got_size(1)), 16'd0);
        tick();

        // Abort together with the handshake on 0101, then K=1.
        clear_got(0);
        start_seq(0, 4'd2);
        tick();
        chk("abort_pre_mask", 0, 16'(bus4.mask), 16'h0005);
        bus4.abort = 1'b1;
        tick();
        bus4.abort = 1'b0;
        chk("abort_valid", 0, 16'(bus4.mask_valid), 16'd0);
        chk("abort_count", 0, 16'(got_size(0)), 16'd1);
        clear_got(0);
        start_seq(0, 4'd1);
        wait_idle(0, 20, 1'b0, cycles);
        chk("k1_count", 0, 16'(got_size(0)), 16'd4);
        for (int i = 0; i < 4; i++) chk("k1_mask", 0, 16'(got_at(0, i)), 16'(exp_w4_k1[i]));
        tick();

        // Asynchronous clear between edges while stalled mid-sequence.
        bus4.mask_ready = 1'b0;
        start_seq(0, 4'd2);
        tick();
        tick();
        #2;
        clear = 1'b1;
        #1;
        chk("aclr_valid", 0, 16'(bus4.mask_valid), 16'd0);
        chk("aclr_busy", 0, 16'(bus4.busy), 16'd0);
        chk("aclr_mask", 0, 16'(bus4.mask), 16'd0);
        chk("aclr_ready", 0, 16'(bus4.start_ready), 16'd1);
        tick();
        clear = 1'b0;
        bus4.mask_ready = 1'b1;
        tick();
        clear_got(0);
        start_seq(0, 4'd2);
        wait_idle(0, 20, 1'b0, cycles);
        chk("aclr_restart_count", 0, 16'(got_size(0)), 16'd6);
        chk("aclr_restart_first", 0, 16'(got_at(0, 0)), 16'h0003);

        // start_valid held high: ignored in RUN, re-accepted in IDLE.
        clear_got(0);
        bus4.start_valid = 1'b1;
        bus4.start_popcount = 4'd2;
        tick();
        chk("hold_busy", 0, 16'(bus4.busy), 16'd1);
        wait_idle(0, 20, 1'b0, cycles);
        chk("hold_first_cycles", 0, 16'(cycles), 16'd6);
        tick();
        chk("hold_reaccept", 0, 16'(bus4.busy), 16'd1);
        bus4.start_valid = 1'b0;
        wait_idle(0, 20, 1'b0, cycles);
        chk("hold_count", 0, 16'(got_size(0)), 16'd12);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
